decoder_3to8_seq: RTL and testbench

- Registered 3-to-8 one-hot decoder with an enable gate. It is the inverse of the team's 8-to-3 encoder and drives one-hot select/strobe lines.
- Two operating modes:
  - DECODE: converts an incoming 3-bit code to one-hot, latency 1.
  - SCAN: autonomously walks the one-hot output through all 8 lines, holding each for a programmable dwell time.
- Sits between control logic and peripheral select lines.

---
 rtl/dec_pkg.sv | 17 +
 rtl/dec_dwell_timer.sv | 30 +++
 rtl/decoder_3to8_seq.sv | 86 ++++++++
 tb/tb_decoder_3to8_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
package dec_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic logic [ONEHOT_W-1:0] onehot3to8(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/dec_dwell_timer.sv
// Dwell counter for SCAN stepping: step is high on the last cycle of each dwell period.
module dec_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic step
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 8'd0;
        end else if (run) begin
            if (cnt == LAST) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign step = run && (cnt == LAST);

endmodule

// File: rtl/decoder_3to8_seq.sv
// Registered 3-to-8 one-hot decoder with DECODE and SCAN modes.
// Optional macro DEC_OVERRUN_EN adds the overrun output for dropped codes.
module decoder_3to8_seq
    import dec_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int PULSE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CODE_W-1:0]   code,
    input  logic                code_valid,
    input  logic                scan_en,
    output logic [ONEHOT_W-1:0] y,
    output logic                y_valid,
`ifdef DEC_OVERRUN_EN
    output logic                overrun,
`endif
    output logic [CODE_W-1:0]   scan_idx
);

    state_t state;
    logic   timer_clr;
    logic   step;

    // The timer only runs while a scan is already in progress and still requested.
    assign timer_clr = !en || !scan_en || (state != SCAN);

    dec_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .run  (!timer_clr),
        .step (step)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state    <= IDLE;
            y        <= '0;
            y_valid  <= 1'b0;
            scan_idx <= '0;
        end else if (scan_en) begin
            if (state != SCAN) begin
                state    <= SCAN;
                y        <= ONEHOT_W'(1);
                scan_idx <= '0;
            end else if (step) begin
                y        <= {y[ONEHOT_W-2:0], y[ONEHOT_W-1]};
                scan_idx <= scan_idx + CODE_W'(1);
            end
            y_valid <= 1'b1;
        end else if (state == SCAN) begin
            state    <= IDLE;
            y        <= '0;
            y_valid  <= 1'b0;
            scan_idx <= '0;
        end else if (code_valid) begin
            state    <= DECODE;
            y        <= onehot3to8(code);
            y_valid  <= 1'b1;
            scan_idx <= '0;
        end else if (state == DECODE && PULSE == 0) begin
            state <= DECODE;
        end else begin
            state   <= IDLE;
            y       <= '0;
            y_valid <= 1'b0;
        end
    end

`ifdef DEC_OVERRUN_EN
    // A code is lost when it meets an active scan or a competing scan request.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            overrun <= 1'b0;
        end else begin
            overrun <= code_valid && (scan_en || state == SCAN);
        end
    end
`endif

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Scoreboard bench: DUT A (DWELL=4, level) and DUT B (DWELL=1, strobe) share inputs.
module tb_decoder_3to8_seq;

    logic       clk = 1'b0;
    logic       rst, en, code_valid, scan_en;
    logic [2:0] code;
    logic [7:0] ya, yb;
    logic       yva, yvb;
    logic [2:0] ia, ib;
    logic       ova, ovb;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         st;
        int         cnt;
        int         idx;
        logic [7:0] y;
        logic       ov;
    } mdl_t;

    typedef struct {
        logic [7:0] ya, yb;
        logic [2:0] ia, ib;
        logic       oa, ob;
    } exp_t;

    mdl_t mA = '{0, 0, 0, 8'h00, 1'b0};
    mdl_t mB = '{0, 0, 0, 8'h00, 1'b0};
    exp_t sb[$];

    always #5 clk = ~clk;

    decoder_3to8_seq #(.DWELL(4), .PULSE(0)) dutA (
        .clk(clk), .rst(rst), .en(en), .code(code), .code_valid(code_valid),
        .scan_en(scan_en), .y(ya), .y_valid(yva),
`ifdef DEC_OVERRUN_EN
        .overrun(ova),
`endif
        .scan_idx(ia)
    );

    decoder_3to8_seq #(.DWELL(1), .PULSE(1)) dutB (
        .clk(clk), .rst(rst), .en(en), .code(code), .code_valid(code_valid),
        .scan_en(scan_en), .y(yb), .y_valid(yvb),
`ifdef DEC_OVERRUN_EN
        .overrun(ovb),
`endif
        .scan_idx(ib)
    );

`ifndef DEC_OVERRUN_EN
    assign ova = 1'b0;
    assign ovb = 1'b0;
`endif

    // States: 0 idle, 1 decode, 2 scan.
    function automatic mdl_t modelNext(input mdl_t m, input int dwell, input int pulse,
                                       input logic r, input logic e, input logic cv,
                                       input logic se, input logic [2:0] c);
        mdl_t n = m;
        n.ov = 1'b0;
        if (r || !e) begin
            n = '{0, 0, 0, 8'h00, 1'b0};
        end else if (se) begin
            n.ov = cv;
            if (m.st != 2) begin
                n.st = 2; n.cnt = 0; n.idx = 0;
            end else if (m.cnt == dwell - 1) begin
                n.cnt = 0; n.idx = (m.idx + 1) % 8;
            end else begin
                n.cnt = m.cnt + 1;
            end
            n.y = 8'h01 << n.idx;
        end else if (m.st == 2) begin
            n = '{0, 0, 0, 8'h00, cv};
        end else if (cv) begin
            n.st = 1; n.y = 8'h01 << c;
        end else if (!(m.st == 1 && pulse == 0)) begin
            n.st = 0; n.y = 8'h00;
        end
        return n;
    endfunction

    task automatic compare(input string tag, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard: observed empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        compare("yA", ya, e.ya);
        compare("yvalidA", 8'(yva), 8'(|e.ya));
        compare("idxA", 8'(ia), 8'(e.ia));
        compare("yB", yb, e.yb);
        compare("yvalidB", 8'(yvb), 8'(|e.yb));
        compare("idxB", 8'(ib), 8'(e.ib));
`ifdef DEC_OVERRUN_EN
        compare("overrunA", 8'(ova), 8'(e.oa));
        compare("overrunB", 8'(ovb), 8'(e.ob));
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic cv,
                                 input logic se, input logic [2:0] c);
        exp_t x;
        rst = r; en = e; code_valid = cv; scan_en = se; code = c;
        mA = modelNext(mA, 4, 0, r, e, cv, se, c);
        mB = modelNext(mB, 1, 1, r, e, cv, se, c);
        x.ya = mA.y; x.ia = 3'(mA.idx); x.oa = mA.ov;
        x.yb = mB.y; x.ib = 3'(mB.idx); x.ob = mB.ov;
        sb.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        compare("resetY", ya, 8'h00);

        applyStimulus(0, 1, 1, 0, 3'd5);
        compare("decode5", ya, 8'h20);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0, 0);
        compare("decodeHold", ya, 8'h20);
        compare("strobeGone", yb, 8'h00);
        applyStimulus(0, 1, 1, 0, 3'd0);
        compare("decode0", ya, 8'h01);
        applyStimulus(0, 0, 0, 0, 0);
        compare("enableOff", ya, 8'h00);

        applyStimulus(0, 1, 1, 0, 3'd2);
        compare("strobe2", yb, 8'h04);
        applyStimulus(0, 1, 1, 0, 3'd7);
        compare("strobe7", yb, 8'h80);
        applyStimulus(0, 1, 0, 0, 0);
        compare("strobeEnd", yb, 8'h00);
        compare("levelHold7", ya, 8'h80);

        for (int k = 1; k <= 40; k++) begin
            applyStimulus(0, 1, 0, 1, 0);
            if (k == 8)  compare("wrapB80", yb, 8'h80);
            if (k == 9)  compare("wrapB01", yb, 8'h01);
            if (k == 32) compare("scanA80", ya, 8'h80);
            if (k == 33) compare("scanAwrapIdx", 8'(ia), 8'h00);
        end
        applyStimulus(0, 1, 0, 0, 0);
        compare("scanDrop", ya, 8'h00);

        applyStimulus(0, 1, 1, 1, 3'd3);
        compare("collision", ya, 8'h01);
`ifdef DEC_OVERRUN_EN
        compare("overrunPulse", 8'(ova), 8'h01);
`endif
        for (int k = 2; k <= 22; k++) applyStimulus(0, 1, 0, 1, 0);
        compare("scanIdx5", 8'(ia), 8'h05);
        applyStimulus(1, 1, 0, 1, 0);
        compare("midScanReset", ya, 8'h00);
        applyStimulus(0, 1, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 9) != 0,
                          1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                          3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
